// File: rtl/vec_pkg.sv
// Shared vector-execute definitions: element types, reduction op codes,
// lane geometry helpers and the reduction FSM state encoding.
package vec_pkg;

  localparam logic [2:0] BYTE_       = 3'd0;
  localparam logic [2:0] HALFWORD_   = 3'd1;
  localparam logic [2:0] WORD_       = 3'd2;
  localparam logic [2:0] DOUBLEWORD_ = 3'd3;
  localparam logic [2:0] VECTOR_     = 3'd4;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_XOR  = 2'd1;
  localparam logic [1:0] OP_MAXU = 2'd2;
  localparam logic [1:0] OP_MINU = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } red_state_e;

  function automatic logic dtype_valid(input logic [2:0] dt);
    return dt <= VECTOR_;
  endfunction

  // Number of lanes in a 128-bit vector; invalid types report one lane.
  function automatic logic [4:0] lane_count(input logic [2:0] dt);
    case (dt)
      BYTE_:       return 5'd16;
      HALFWORD_:   return 5'd8;
      WORD_:       return 5'd4;
      DOUBLEWORD_: return 5'd2;
      default:     return 5'd1;
    endcase
  endfunction

  function automatic logic [7:0] lane_width(input logic [2:0] dt);
    case (dt)
      BYTE_:       return 8'd8;
      HALFWORD_:   return 8'd16;
      WORD_:       return 8'd32;
      DOUBLEWORD_: return 8'd64;
      VECTOR_:     return 8'd128;
      default:     return 8'd0;
    endcase
  endfunction

  // Invalid types mask to zero so nothing leaks into the accumulator.
  function automatic logic [127:0] lane_mask(input logic [2:0] dt);
    case (dt)
      BYTE_:       return 128'hFF;
      HALFWORD_:   return 128'hFFFF;
      WORD_:       return 128'hFFFF_FFFF;
      DOUBLEWORD_: return 128'hFFFF_FFFF_FFFF_FFFF;
      VECTOR_:     return {128{1'b1}};
      default:     return 128'h0;
    endcase
  endfunction

  // Moves lane 1 down into lane 0 position.
  function automatic logic [127:0] lane_shift(input logic [127:0] v, input logic [2:0] dt);
    return v >> lane_width(dt);
  endfunction

endpackage

// File: rtl/reducev_lane_op.sv
// Combinational lane combiner: y = f(a, b) at the element width, upper bits zero.
module reducev_lane_op
  import vec_pkg::*;
(
  input  logic [127:0] a,
  input  logic [127:0] b,
  input  logic [1:0]   op,
  input  logic [2:0]   dtype,
  output logic [127:0] y
);

  logic [127:0] mask;
  logic [127:0] am;
  logic [127:0] bm;

  assign mask = lane_mask(dtype);
  assign am   = a & mask;
  assign bm   = b & mask;

  // Masked operands make the unsigned compares exact at width w.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = (am + bm) & mask;
      OP_XOR:  y = am ^ bm;
      OP_MAXU: y = (am > bm) ? am : bm;
      OP_MINU: y = (am < bm) ? am : bm;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/reducev.sv
// Horizontal vector reduction: folds all lanes of a 128-bit vector into one
// zero-extended scalar, one lane per cycle, with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for a request; accept latches vector, type and op
// RUN   | fold lane 1 of the shift register into acc each cycle
// DONE  | result/err presented until consumer accepts
module reducev
  import vec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] vec,
  input  logic [2:0]   dtype,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] result,
  output logic         err
);

  red_state_e   state_q, state_d;
  logic [127:0] shreg_q, shreg_d;
  logic [2:0]   dtype_q, dtype_d;
  logic [1:0]   op_q, op_d;
  logic [127:0] acc_q, acc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         err_q, err_d;

  logic [127:0] lane1;
  logic [127:0] fold;

  assign lane1 = lane_shift(shreg_q, dtype_q);

  reducev_lane_op u_lane_op (
    .a     (acc_q),
    .b     (lane1),
    .op    (op_q),
    .dtype (dtype_q),
    .y     (fold)
  );

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = acc_q;
  assign err       = err_q;

  // Next-state and datapath update for accept, fold and hand-off.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dtype_d = dtype_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = vec;
          dtype_d = dtype;
          op_d    = op;
          if (!dtype_valid(dtype)) begin
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = vec & lane_mask(dtype);
            cnt_d   = 4'(lane_count(dtype) - 5'd1);
            err_d   = 1'b0;
            state_d = (lane_count(dtype) > 5'd1) ? ST_RUN : ST_DONE;
          end
        end
      end
      ST_RUN: begin
        shreg_d = lane1;
        acc_d   = fold;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dtype_q <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dtype_q <= dtype_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_reducev.sv
// Scoreboard bench for reducev: driver pushes expected results, monitor pops
// and compares whenever out_valid rises, then checks that outputs hold.
module tb_reducev;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] vec = '0;
  logic [2:0]   dtype = '0;
  logic [1:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] result;
  logic         err;

  reducev dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec       (vec),
    .dtype     (dtype),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] res;
    logic         er;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference: lanes extracted arithmetically and folded in a plain loop.
  function automatic void ref_model(input logic [127:0] v, input logic [2:0] dt, input logic [1:0] o,
                                    output logic [127:0] r, output logic e, output int n);
    int w;
    logic [127:0] mask, acc, lane;
    e = 1'b0;
    case (dt)
      3'd0: begin w = 8;   n = 16; end
      3'd1: begin w = 16;  n = 8;  end
      3'd2: begin w = 32;  n = 4;  end
      3'd3: begin w = 64;  n = 2;  end
      3'd4: begin w = 128; n = 1;  end
      default: begin w = 0; n = 1; end
    endcase
    if (w == 0) begin
      r = '0;
      e = 1'b1;
      return;
    end
    if (w == 128) begin
      r = v;
      return;
    end
    mask = (128'd1 << w) - 128'd1;
    acc  = v & mask;
    for (int i = 1; i < n; i++) begin
      lane = (v >> (i * w)) & mask;
      case (o)
        2'd0: acc = (acc + lane) % (128'd1 << w);
        2'd1: acc = acc ^ lane;
        2'd2: if (lane > acc) acc = lane;
        default: if (lane < acc) acc = lane;
      endcase
    end
    r = acc;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [127:0] v, input logic [2:0] dt, input logic [1:0] o,
                       input logic [127:0] er, input logic ee, input int lat);
    exp_t x;
    int waited = 0;
    while (!in_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        errors++;
        $display("FAIL issue_timeout: in_ready still %0b after %0d cycles, want 1", in_ready, waited);
        return;
      end
    end
    in_valid = 1'b1;
    vec = v;
    dtype = dt;
    op = o;
    x.res = er;
    x.er = ee;
    x.lat = lat;
    x.acc_cyc = cyc + 1;
    exp_q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
    vec = {$urandom, $urandom, $urandom, $urandom};
    dtype = 3'($urandom_range(0, 7));
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic issue_model(input logic [127:0] v, input logic [2:0] dt, input logic [1:0] o);
    logic [127:0] r;
    logic e;
    int n;
    ref_model(v, dt, o, r, e, n);
    issue(v, dt, o, r, e, n);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      waited++;
      if (waited > 500) begin
        errors++;
        $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
        exp_q.delete();
        return;
      end
    end
  endtask

  // Monitor: compare on first out_valid cycle, then require stable outputs.
  logic         seen = 1'b0;
  logic [127:0] held_res;
  logic         held_err;
  always @(negedge clk) begin
    if (out_valid) begin
      if (!seen) begin
        exp_t x;
        seen = 1'b1;
        held_res = result;
        held_err = err;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 result=%h with no request outstanding", result);
        end else begin
          x = exp_q.pop_front();
          chk("result", result, x.res);
          chk("err", 128'(err), 128'(x.er));
          chk("latency", 128'(cyc - x.acc_cyc + 1), 128'(x.lat));
        end
      end else begin
        chk("hold_result", result, held_res);
        chk("hold_err", 128'(err), 128'(held_err));
      end
    end else begin
      seen = 1'b0;
    end
  end

  always @(negedge clk) if (rand_bp) out_ready = 1'($urandom_range(0, 1));

  initial begin
    logic [127:0] v;
    int waited;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_result", result, 128'd0);
    chk("rst_err", 128'(err), 128'd0);

    // BYTE ADD lanes 1..16
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i + 1);
    issue(v, 3'd0, 2'd0, 128'h88, 1'b0, 16);
    drain();
    // BYTE ADD all 0xFF wraps
    issue({128{1'b1}}, 3'd0, 2'd0, 128'hF0, 1'b0, 16);
    drain();
    // WORD MAXU / MINU
    v = {32'hFFFF_FFFE, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000};
    issue(v, 3'd2, 2'd2, 128'hFFFF_FFFE, 1'b0, 4);
    issue(v, 3'd2, 2'd3, 128'h1, 1'b0, 4);
    drain();
    // DOUBLEWORD XOR
    v = {64'hFFFF_0000_FFFF_0000, 64'hAAAA_AAAA_AAAA_AAAA};
    issue(v, 3'd3, 2'd1, 128'h5555_AAAA_5555_AAAA, 1'b0, 2);
    drain();
    // VECTOR passes through for every op
    for (int o = 0; o < 4; o++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      issue(v, 3'd4, 2'(o), v, 1'b0, 1);
    end
    drain();
    // Invalid dtype
    issue({$urandom, $urandom, $urandom, $urandom}, 3'd6, 2'd0, 128'd0, 1'b1, 1);
    drain();

    // HALFWORD ADD with 5 cycles of backpressure in DONE
    out_ready = 1'b0;
    issue_model({$urandom, $urandom, $urandom, $urandom}, 3'd1, 2'd0);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("bp_out_valid_seen", 128'(out_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    drain();

    // HALFWORD ADD with reset in the 3rd RUN cycle
    issue_model({$urandom, $urandom, $urandom, $urandom}, 3'd1, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mid_rst_no_out", 128'(out_valid), 128'd0);
    end
    issue_model({$urandom, $urandom, $urandom, $urandom}, 3'd1, 2'd0);
    drain();

    // Randomized traffic, first with out_ready high, then random backpressure
    for (int pass = 0; pass < 2; pass++) begin
      rand_bp = (pass == 1);
      for (int t = 0; t < 40; t++) begin
        logic [2:0] dt;
        dt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        issue_model({$urandom, $urandom, $urandom, $urandom}, dt, 2'($urandom_range(0, 3)));
      end
      rand_bp = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
